alu_exec_unit: RTL and testbench

Execution unit that consumes the 4-bit ctrl code produced by alu_control and performs the selected operation on two operands. Single-cycle logical and arithmetic ops complete in one cycle. MULTU and DIVU run iteratively and write internal HI/LO registers, which MFHI and MFLO read back. Sits in the EX stage; the control FSM drives start and stalls on busy.

---
 rtl/alu_exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execution unit. Single-cycle logic and arithmetic ops,
// plus iterative MULTU/DIVU that write the internal HI/LO registers read back by MFHI/MFLO.
// Latency: single-cycle ops (and DIVU by zero) raise done 1 cycle after the start edge.
//          MULTU/DIVU raise done WIDTH+1 cycles after the start edge.
// Backpressure: busy is high while MULTU/DIVU iterate. Any start seen while busy is dropped.
// Ports: clk, reset (sync, active-high), start/ctrl/a/b request, result/zero registered
//        outputs, busy, done pulse.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;     // working {hi, lo} during iteration
    logic [WIDTH-1:0]       op_a_q, op_a_d;   // multiplicand
    logic [WIDTH-1:0]       op_b_q, op_b_d;   // multiplier (shifted) or divisor
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   done_q, done_d;

    logic [WIDTH-1:0]       single_res;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic                   div_ok;
    logic [2*WIDTH-1:0]     mul_next;
    logic [2*WIDTH-1:0]     div_next;
    logic                   last_iter;

    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);

    // Single-cycle operation result from the live inputs.
    always_comb begin
        single_res = '0;
        unique case (ctrl)
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  single_res = ~(a | b);
            OP_MFHI: single_res = hi_q;
            OP_MFLO: single_res = lo_q;
            default: single_res = '0;
        endcase
    end

    // One shift-add step: product bits fall out of the upper half into the lower half.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (op_b_q[0] ? {1'b0, op_a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-division step: upper half is the partial remainder, lower half
    // shifts the dividend out and the quotient in. Bit WIDTH of the difference is the borrow.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, op_b_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};

    assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ctrl == OP_MULT) begin
                        op_a_d  = a;
                        op_b_d  = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else if (ctrl == OP_DIV) begin
                        if (b == '0) begin
                            // Divide by zero resolves immediately without iterating.
                            lo_d   = '1;
                            hi_d   = a;
                            done_d = 1'b1;
                        end else begin
                            op_b_d  = b;
                            acc_d   = {{WIDTH{1'b0}}, a};
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d  = mul_next;
                op_b_d = op_b_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d    = div_next[2*WIDTH-1:WIDTH];
                    lo_d    = div_next[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        ctrl;
    logic [WIDTH-1:0]  a, b;
    logic [WIDTH-1:0]  result;
    logic              zero, busy, done;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: architectural view only.
    logic [31:0] m_hi = '0, m_lo = '0, m_result = '0;

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .ctrl(ctrl), .a(a), .b(b),
        .result(result), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_single(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            4'b1010: return m_hi;
            4'b1011: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one op, wait for done, compare latency/busy/result against the model.
    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int exp_lat;
        bit busy_seen;
        logic [63:0] p;
        exp_lat = 1;
        if (c == 4'b1000) begin
            exp_lat = WIDTH + 1;
            p = 64'(x) * 64'(y);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (c == 4'b1001) begin
            if (y == 0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = x;
            end else begin
                exp_lat = WIDTH + 1;
                m_lo = x / y;
                m_hi = x % y;
            end
        end else begin
            m_result = ref_single(c, x, y);
        end
        @(negedge clk);
        ctrl = c; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ctrl = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        busy_seen = 1'b0;
        while (!done && lat < 100) begin
            busy_seen |= busy;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("busy_seen", {31'b0, busy_seen}, {31'b0, exp_lat > 1});
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("result", result, m_result);
        chk("zero", {31'b0, zero}, {31'b0, m_result == 0});
        @(negedge clk);
        chk("done_single_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [3:0] codes [12];
        logic [3:0] c;
        logic [31:0] x, y;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                  4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0101, 4'b1111};

        reset = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        run_op(4'b1010, 0, 0);
        chk("rst_hi", result, 32'd0);

        // Directed cases.
        run_op(4'b0010, 5, 7);
        chk("add_5_7", result, 32'd12);
        run_op(4'b0110, 7, 7);
        chk("sub_zero_flag", {31'b0, zero}, 32'd1);
        run_op(4'b0111, 32'hFFFF_FFFF, 1);
        chk("slt_neg", result, 32'd1);
        run_op(4'b1100, 0, 0);
        chk("nor_0_0", result, 32'hFFFF_FFFF);
        run_op(4'b0101, 32'h1234, 32'h5678);
        chk("unknown_ctrl", result, 32'd0);
        run_op(4'b1000, 32'hFFFF_FFFF, 2);
        run_op(4'b1010, 0, 0);
        chk("mfhi_after_mul", result, 32'h1);
        run_op(4'b1011, 0, 0);
        chk("mflo_after_mul", result, 32'hFFFF_FFFE);
        run_op(4'b1001, 100, 7);
        run_op(4'b1011, 0, 0);
        chk("div_quot", result, 32'd14);
        run_op(4'b1010, 0, 0);
        chk("div_rem", result, 32'd2);
        run_op(4'b1001, 9, 0);
        run_op(4'b1011, 0, 0);
        chk("div0_lo", result, 32'hFFFF_FFFF);
        run_op(4'b1010, 0, 0);
        chk("div0_hi", result, 32'd9);

        // Back-to-back single-cycle ops: done every cycle.
        @(negedge clk);
        ctrl = 4'b0010; a = 1; b = 2; start = 1'b1;
        @(negedge clk);
        chk("b2b_done1", {31'b0, done}, 32'd1);
        chk("b2b_res1", result, 32'd3);
        ctrl = 4'b0110; a = 9; b = 4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", {31'b0, done}, 32'd1);
        chk("b2b_res2", result, 32'd5);
        m_result = 32'd5;
        @(negedge clk);
        chk("b2b_done_off", {31'b0, done}, 32'd0);

        // Start during busy is ignored: one done, result unchanged.
        @(negedge clk);
        ctrl = 4'b1000; a = 32'd1000; b = 32'd3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        ctrl = 4'b0010; a = 32'd50; b = 32'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("busy_ignore_dones", dones, 1);
        chk("busy_ignore_result", result, m_result);
        m_hi = 32'd0; m_lo = 32'd3_000_000;
        run_op(4'b1011, 0, 0);

        // Reset in the middle of a DIVU aborts it.
        @(negedge clk);
        ctrl = 4'b1001; a = 100; b = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_result = '0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        run_op(4'b0010, 20, 22);
        run_op(4'b1010, 0, 0);
        run_op(4'b1011, 0, 0);

        // Randomized ops against the model.
        for (int n = 0; n < 40; n++) begin
            c = codes[$urandom_range(0, 11)];
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_op(c, x, y);
            if (c == 4'b1000 || c == 4'b1001) begin
                run_op(4'b1010, $urandom, $urandom);
                run_op(4'b1011, $urandom, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
